// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator.
//
// Purpose:
//   Produces hsync/vsync/display-enable and raw x/y positions for a raster
//   display. Horizontal and vertical timing (active, front porch, sync, back
//   porch), sync polarities and counter width are set by parameters. The pixel
//   rate comes from an external strobe (pix_en) rather than an internal divider.
//   All outputs are registered and lag the internal counters by one strobe.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   pix_en       pixel strobe; timing advances one pixel per clk edge with pix_en=1
//   restart      synchronous frame restart (overrides pix_en)
//   hsync        horizontal sync, active level HS_POL
//   vsync        vertical sync, active level VS_POL
//   de           display enable, high inside the active region
//   x, y         raw horizontal / vertical counts, including blanking
//   line_start   one-clk pulse when x=0 of any line is presented
//   frame_start  one-clk pulse when (0,0) is presented
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  input  logic          restart,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Thresholds are one bit wider than the counters so that a total of exactly
  // 2^CW is still representable.
  localparam logic [CW:0] H_ACT_W   = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] H_SYNC_ON = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] H_SYNC_OF = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] H_LAST    = (CW+1)'(H_TOTAL - 1);
  localparam logic [CW:0] V_ACT_W   = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] V_SYNC_ON = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] V_SYNC_OF = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW:0] V_LAST    = (CW+1)'(V_TOTAL - 1);

  if (CW < 1 || CW > 31 ||
      H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      longint'(H_TOTAL) > (longint'(1) << CW) ||
      longint'(V_TOTAL) > (longint'(1) << CW)) begin : g_bad_params
    $error("vga_timing_gen: illegal timing parameters or counter width");
  end

  logic [CW-1:0] r_h_cnt;
  logic [CW-1:0] r_v_cnt;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_de;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_line_start;
  logic          r_frame_start;

  logic [CW:0]   w_h_ext;
  logic [CW:0]   w_v_ext;
  logic          w_h_last;
  logic          w_v_last;
  logic [CW-1:0] w_h_next;
  logic [CW-1:0] w_v_next;
  logic          w_de;
  logic          w_hs_act;
  logic          w_vs_act;
  logic          w_line0;
  logic          w_frame0;

  // Decode of the counters as they stand before the next strobe.
  always_comb begin
    w_h_ext  = {1'b0, r_h_cnt};
    w_v_ext  = {1'b0, r_v_cnt};
    w_h_last = (w_h_ext == H_LAST);
    w_v_last = (w_v_ext == V_LAST);
    w_h_next = w_h_last ? '0 : r_h_cnt + CW'(1);
    // Vertical count only moves on the horizontal wrap.
    w_v_next = r_v_cnt;
    if (w_h_last) begin
      w_v_next = w_v_last ? '0 : r_v_cnt + CW'(1);
    end
    w_de     = (w_h_ext < H_ACT_W) && (w_v_ext < V_ACT_W);
    w_hs_act = (w_h_ext >= H_SYNC_ON) && (w_h_ext < H_SYNC_OF);
    w_vs_act = (w_v_ext >= V_SYNC_ON) && (w_v_ext < V_SYNC_OF);
    w_line0  = (r_h_cnt == '0);
    w_frame0 = (r_h_cnt == '0) && (r_v_cnt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_de          <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (restart) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_de          <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (pix_en) begin
      r_h_cnt       <= w_h_next;
      r_v_cnt       <= w_v_next;
      r_hsync       <= w_hs_act ? HS_POL : ~HS_POL;
      r_vsync       <= w_vs_act ? VS_POL : ~VS_POL;
      r_de          <= w_de;
      r_x           <= r_h_cnt;
      r_y           <= r_v_cnt;
      r_line_start  <= w_line0;
      r_frame_start <= w_frame0;
    end else begin
      // Pulses last exactly one clk even when strobes are sparse.
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule
